// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory port between the I-cache fill FSM
// and the D-cache fill/write-through path; one transaction at a time.
module memory_arbiter #(
    parameter int BLOCK_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ICacheRequest,
    input  logic [15:0] ICacheAddress,
    input  logic        DCacheRequest,
    input  logic [15:0] DCacheAddress,
    input  logic        DCacheWrite,
    input  logic [15:0] DCacheWriteData,
    input  logic        MemoryDataValid,
    input  logic [15:0] MemoryDataIn,
    output logic        MemoryEnable,
    output logic        MemoryWrite,
    output logic [15:0] MemoryAddressOut,
    output logic [15:0] MemoryDataOut,
    output logic        ICacheGrant,
    output logic        DCacheGrant,
    output logic        ICacheDataValid,
    output logic        DCacheDataValid,
    output logic [15:0] FillDataOut
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D_READ,
        SERVE_D_WRITE
    } state_t;

    localparam logic [2:0] LAST_BEAT = 3'(BLOCK_WORDS - 1);

    state_t     state_q, state_d;
    logic [2:0] beat_q, beat_d;
    logic       last_d_q, last_d_d;   // 1: D was served last, so I wins a tie

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            last_d_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            last_d_q <= last_d_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        last_d_d = last_d_q;
        unique case (state_q)
            IDLE: begin
                if (ICacheRequest && (!DCacheRequest || last_d_q)) begin
                    state_d  = SERVE_I;
                    last_d_d = 1'b0;
                end else if (DCacheRequest) begin
                    state_d  = DCacheWrite ? SERVE_D_WRITE : SERVE_D_READ;
                    last_d_d = 1'b1;
                end
            end
            SERVE_I, SERVE_D_READ: begin
                if (MemoryDataValid) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end
            end
            SERVE_D_WRITE: state_d = IDLE;
            default:       state_d = IDLE;
        endcase
    end

    // Outputs are forced low while rst is high, even before the state register clears.
    always_comb begin
        MemoryEnable     = 1'b0;
        MemoryWrite      = 1'b0;
        MemoryAddressOut = '0;
        MemoryDataOut    = '0;
        ICacheGrant      = 1'b0;
        DCacheGrant      = 1'b0;
        ICacheDataValid  = 1'b0;
        DCacheDataValid  = 1'b0;
        if (!rst) begin
            unique case (state_q)
                SERVE_I: begin
                    ICacheGrant      = 1'b1;
                    MemoryEnable     = 1'b1;
                    MemoryAddressOut = ICacheAddress;
                    ICacheDataValid  = MemoryDataValid;
                end
                SERVE_D_READ: begin
                    DCacheGrant      = 1'b1;
                    MemoryEnable     = 1'b1;
                    MemoryAddressOut = DCacheAddress;
                    DCacheDataValid  = MemoryDataValid;
                end
                SERVE_D_WRITE: begin
                    DCacheGrant      = 1'b1;
                    MemoryEnable     = 1'b1;
                    MemoryWrite      = 1'b1;
                    MemoryAddressOut = DCacheAddress;
                    MemoryDataOut    = DCacheWriteData;
                end
                default: ;
            endcase
        end
    end

    assign FillDataOut = MemoryDataIn;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench: the driver predicts grants, beats and stores from the
// round-robin rules; a negedge monitor pops and compares what the arbiter shows.
module tb_memory_arbiter;

    localparam int BW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ICacheRequest, DCacheRequest, DCacheWrite, MemoryDataValid;
    logic [15:0] ICacheAddress, DCacheAddress, DCacheWriteData, MemoryDataIn;
    logic        MemoryEnable, MemoryWrite, ICacheGrant, DCacheGrant;
    logic        ICacheDataValid, DCacheDataValid;
    logic [15:0] MemoryAddressOut, MemoryDataOut, FillDataOut;

    always #5 clk = ~clk;

    memory_arbiter #(.BLOCK_WORDS(BW)) dut (
        .clk             (clk),
        .rst             (rst),
        .ICacheRequest   (ICacheRequest),
        .ICacheAddress   (ICacheAddress),
        .DCacheRequest   (DCacheRequest),
        .DCacheAddress   (DCacheAddress),
        .DCacheWrite     (DCacheWrite),
        .DCacheWriteData (DCacheWriteData),
        .MemoryDataValid (MemoryDataValid),
        .MemoryDataIn    (MemoryDataIn),
        .MemoryEnable    (MemoryEnable),
        .MemoryWrite     (MemoryWrite),
        .MemoryAddressOut(MemoryAddressOut),
        .MemoryDataOut   (MemoryDataOut),
        .ICacheGrant     (ICacheGrant),
        .DCacheGrant     (DCacheGrant),
        .ICacheDataValid (ICacheDataValid),
        .DCacheDataValid (DCacheDataValid),
        .FillDataOut     (FillDataOut)
    );

    typedef enum int {EV_GI, EV_GD, EV_BI, EV_BD, EV_WR} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [15:0] addr;
        logic [15:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  passed = 0;
    bit  last_was_d = 1'b1;   // reference round-robin memory

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic expect_ev(input ev_kind_t kind, input logic [15:0] addr, input logic [15:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_event: got kind %0d addr %h data %h expected none", kind, addr, data);
        end else begin
            e = exp_q.pop_front();
            chk("event", {8'(kind), addr, data}, {8'(e.kind), e.addr, e.data});
        end
    endtask

    // Monitor
    logic prev_ig = 1'b0, prev_dg = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            chk("invariants",
                {63'd0,
                 (MemoryEnable == (ICacheGrant | DCacheGrant)) && !(ICacheGrant && DCacheGrant) &&
                 (MemoryWrite ? DCacheGrant : (MemoryDataOut == 16'h0)) &&
                 (!ICacheDataValid || (ICacheGrant && MemoryDataValid)) &&
                 (!DCacheDataValid || (DCacheGrant && MemoryDataValid))},
                64'd1);
            if (ICacheGrant && !prev_ig) expect_ev(EV_GI, MemoryAddressOut, 16'h0);
            if (DCacheGrant && !prev_dg) expect_ev(EV_GD, MemoryAddressOut, 16'h0);
            if (MemoryWrite)     expect_ev(EV_WR, MemoryAddressOut, MemoryDataOut);
            if (ICacheDataValid) expect_ev(EV_BI, MemoryAddressOut, FillDataOut);
            if (DCacheDataValid) expect_ev(EV_BD, MemoryAddressOut, FillDataOut);
        end
        prev_ig = ICacheGrant;
        prev_dg = DCacheGrant;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_addrs(input bit win_d, input logic [15:0] a);
        if (win_d) begin
            DCacheAddress = a;
            ICacheAddress = 16'($urandom);
        end else begin
            ICacheAddress = a;
            DCacheAddress = 16'($urandom);
        end
    endtask

    task automatic fill(input bit win_d, input logic [15:0] base, input int nbeats, input int raise_d_at);
        for (int k = 0; k < nbeats; k++) begin
            int gaps;
            gaps = $urandom_range(0, 2);
            drive_addrs(win_d, 16'(base + 16'(k)));
            if (k == raise_d_at) DCacheRequest = 1'b1;
            if (k == 1 && $urandom_range(0, 1) == 1) begin
                if (win_d) DCacheRequest = 1'b0;
                else       ICacheRequest = 1'b0;
            end
            for (int g = 0; g < gaps; g++) begin
                MemoryDataValid = 1'b0;
                MemoryDataIn    = 16'($urandom);
                step();
                drive_addrs(win_d, 16'(base + 16'(k)));
            end
            MemoryDataValid = 1'b1;
            MemoryDataIn    = 16'($urandom);
            exp_q.push_back('{win_d ? EV_BD : EV_BI, 16'(base + 16'(k)), MemoryDataIn});
            step();
        end
        MemoryDataValid = 1'b0;
    endtask

    task automatic txn(input bit ri, input bit rd, input bit dw, input logic [15:0] base,
                       input logic [15:0] wdata, input int raise_d_at);
        bit win_d;
        ICacheRequest   = ri;
        DCacheRequest   = rd;
        DCacheWrite     = dw;
        DCacheWriteData = wdata;
        MemoryDataValid = 1'($urandom_range(0, 1));   // stray beat in IDLE must be ignored
        MemoryDataIn    = 16'($urandom);
        if (!ri && !rd) begin
            step();
            return;
        end
        win_d      = (ri && rd) ? !last_was_d : rd;
        last_was_d = win_d;
        drive_addrs(win_d, base);
        exp_q.push_back('{win_d ? EV_GD : EV_GI, base, 16'h0});
        if (win_d && dw) exp_q.push_back('{EV_WR, base, wdata});
        step();
        chk("grant_latency", {63'd0, win_d ? DCacheGrant : ICacheGrant}, 64'd1);
        if (win_d && dw) begin
            MemoryDataValid = 1'($urandom_range(0, 1));
            DCacheRequest   = 1'($urandom_range(0, 1));
            step();
        end else begin
            fill(win_d, base, BW, raise_d_at);
        end
        MemoryDataValid = 1'b0;
        chk("idle_after_txn", {60'd0, ICacheGrant, DCacheGrant, MemoryEnable, MemoryWrite}, 64'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name, {26'd0, ICacheGrant, DCacheGrant, MemoryEnable, MemoryWrite,
                   ICacheDataValid, DCacheDataValid, MemoryAddressOut, MemoryDataOut}, 64'd0);
        chk({name, "_fill"}, {48'd0, FillDataOut}, {48'd0, MemoryDataIn});
    endtask

    task automatic apply_reset();
        rst             = 1'b1;
        MemoryDataValid = 1'b1;
        MemoryDataIn    = 16'($urandom);
        step();
        step();
        check_reset_outputs("reset_outputs");
        rst             = 1'b0;
        MemoryDataValid = 1'b0;
        last_was_d      = 1'b1;
    endtask

    // Reset lands after the fifth beat of a D fill; the fill must be abandoned.
    task automatic reset_mid_dfill(input logic [15:0] base);
        ICacheRequest   = 1'b0;
        DCacheRequest   = 1'b1;
        DCacheWrite     = 1'b0;
        MemoryDataValid = 1'b0;
        last_was_d      = 1'b1;
        drive_addrs(1'b1, base);
        exp_q.push_back('{EV_GD, base, 16'h0});
        step();
        chk("dfill_grant", {63'd0, DCacheGrant}, 64'd1);
        fill(1'b1, base, 5, -1);
        rst             = 1'b1;
        DCacheRequest   = 1'b0;
        MemoryDataValid = 1'b1;
        MemoryDataIn    = 16'($urandom);
        #1;
        check_reset_outputs("midfill_rst_outputs");
        step();
        rst             = 1'b0;
        MemoryDataValid = 1'b0;
        last_was_d      = 1'b1;
        chk("post_rst_idle", {61'd0, ICacheGrant, DCacheGrant, MemoryEnable}, 64'd0);
    endtask

    initial begin
        #200000;
        checks++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("%0d/%0d checks passed", passed, checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        ICacheRequest = 1'b0; DCacheRequest = 1'b0; DCacheWrite = 1'b0;
        ICacheAddress = '0; DCacheAddress = '0; DCacheWriteData = '0;
        MemoryDataValid = 1'b0; MemoryDataIn = '0;

        apply_reset();
        txn(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0, -1);
        apply_reset();
        txn(1'b1, 1'b1, 1'b0, 16'($urandom), 16'h0, -1);
        txn(1'b1, 1'b1, 1'b0, 16'($urandom), 16'h0, -1);
        txn(1'b0, 1'b1, 1'b1, 16'h2000, 16'hBEEF, -1);
        txn(1'b1, 1'b0, 1'b0, 16'($urandom), 16'h0, 3);
        txn(1'b0, 1'b1, 1'b0, 16'($urandom), 16'h0, -1);
        reset_mid_dfill(16'h3000);
        txn(1'b1, 1'b1, 1'b0, 16'h4000, 16'h0, -1);

        for (int n = 0; n < 30; n++) begin
            txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                16'($urandom), 16'($urandom), -1);
        end

        ICacheRequest = 1'b0;
        DCacheRequest = 1'b0;
        step();
        step();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter BLOCK_WORDS, default 8: data beats per cache-line fill; legal values are powers of two from 2 to 8.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port ICacheRequest, input, 1 bit: I-cache fill FSM requests memory.
REQ-005 SHALL have port ICacheAddress, input, 16 bits: I-cache beat address, driven by its fill FSM.
REQ-006 SHALL have port DCacheRequest, input, 1 bit: D-cache fill or store requests memory.
REQ-007 SHALL have port DCacheAddress, input, 16 bits: D-cache beat or store address.
REQ-008 SHALL have port DCacheWrite, input, 1 bit: the D-cache request is a write-through store.
REQ-009 SHALL have port DCacheWriteData, input, 16 bits: store data.
REQ-010 SHALL have port MemoryDataValid, input, 1 bit: memory returns one read beat this cycle.
REQ-011 SHALL have port MemoryDataIn, input, 16 bits: read beat data.
REQ-012 SHALL have port MemoryEnable, output, 1 bit: memory access active.
REQ-013 SHALL have port MemoryWrite, output, 1 bit: memory access is a write.
REQ-014 SHALL have port MemoryAddressOut, output, 16 bits: the owner's address.
REQ-015 SHALL have port MemoryDataOut, output, 16 bits: store data to memory.
REQ-016 SHALL have ports ICacheGrant and DCacheGrant, output, 1 bit each: the current owner of memory.
REQ-017 SHALL have ports ICacheDataValid and DCacheDataValid, output, 1 bit each: MemoryDataValid routed to the owner.
REQ-018 SHALL have port FillDataOut, output, 16 bits: MemoryDataIn passed through unchanged.

Function
REQ-019 SHALL implement states IDLE, SERVE_I, SERVE_D_READ and SERVE_D_WRITE.
REQ-020 In IDLE, all grants, MemoryEnable and MemoryWrite SHALL be 0, and MemoryDataValid SHALL be ignored.
REQ-021 In IDLE, if exactly one request is high, that requester SHALL win. The next state is SERVE_I for I, SERVE_D_WRITE for D with DCacheWrite=1, and SERVE_D_READ for D with DCacheWrite=0.
REQ-022 When both requests are high in IDLE, the requester not in the LastServed register SHALL win (round-robin). LastServed SHALL update on entry to a SERVE state.
REQ-023 In any SERVE state, the owner's grant and MemoryEnable SHALL be 1, and MemoryAddressOut SHALL equal the owner's address combinationally.
REQ-024 In SERVE_I and SERVE_D_READ, the 3-bit BeatCount SHALL increment on each MemoryDataValid.
REQ-025 In SERVE_I and SERVE_D_READ, the owner's DataValid SHALL equal MemoryDataValid; the non-owner's DataValid SHALL be 0.
REQ-026 When MemoryDataValid arrives with BeatCount==BLOCK_WORDS-1, the arbiter SHALL return to IDLE on the next edge and clear BeatCount.
REQ-027 SERVE_D_WRITE SHALL last exactly one cycle: MemoryWrite=1, MemoryDataOut=DCacheWriteData, then IDLE.
REQ-028 Outside SERVE_D_WRITE, MemoryWrite SHALL be 0 and MemoryDataOut SHALL be 0.
REQ-029 Requests SHALL be ignored while in any SERVE state. A fill SHALL NOT be aborted if the owner drops its request; it completes all BLOCK_WORDS beats.
REQ-030 At least one IDLE cycle SHALL separate consecutive transactions. Latency from a request in IDLE to its grant SHALL be 1 cycle.
REQ-031 BeatCount SHALL wrap to 0 only via REQ-026; it SHALL never exceed BLOCK_WORDS-1.

Reset
REQ-032 When rst=1 at an edge, state SHALL become IDLE, BeatCount 0, and LastServed D (so I wins the first tie). This SHALL apply even mid-fill.
REQ-033 During reset, all outputs SHALL be 0 except FillDataOut, which follows MemoryDataIn.

Verification
REQ-034 Bench SHALL cover: ICacheRequest=1 with address 0x0100 from IDLE -> ICacheGrant=1 next cycle; 8 valid beats forwarded on ICacheDataValid; IDLE after the 8th.
REQ-035 Bench SHALL cover: both requests high after reset -> I granted first; after its 8 beats plus one IDLE cycle, D granted.
REQ-036 Bench SHALL cover: DCacheRequest=1, DCacheWrite=1, address 0x2000, data 0xBEEF -> one cycle with MemoryWrite=1, MemoryAddressOut=0x2000, MemoryDataOut=0xBEEF.
REQ-037 Bench SHALL cover: DCacheRequest rising during SERVE_I beat 3 -> no DCacheGrant until SERVE_I completes; ICacheDataValid never pulses while D owns memory.
REQ-038 Bench SHALL cover: rst=1 after beat 5 of a D fill -> next cycle IDLE, grants 0, BeatCount 0; the next tie grants I.
